// File: rtl/game_pkg.sv
// Shared game-flow types: state encoding, default frame counts and
// the screen-select decode used by the sequencer and the drawing mux.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_PULSE = 3'd1,
    PLAYING     = 3'd2,
    LEVEL_CLEAR = 3'd3,
    GAME_OVER   = 3'd4,
    WIN         = 3'd5
  } game_state_t;

  localparam int unsigned CLEAR_FRAMES_DEF = 120;
  localparam int unsigned END_FRAMES_DEF   = 180;

  typedef struct packed {
    logic play;
    logic start;
    logic clear;
    logic over;
    logic win;
  } screen_t;

  function automatic screen_t screen_of(input game_state_t s);
    screen_t f;
    f = '0;
    case (s)
      IDLE:        f.start = 1'b1;
      PLAYING:     f.play  = 1'b1;
      LEVEL_CLEAR: f.clear = 1'b1;
      GAME_OVER:   f.over  = 1'b1;
      WIN:         f.win   = 1'b1;
      default:     f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/game_state_ctrl_key_edge_detect.sv
// Key sync register plus rising-edge pulse; one cycle per 0->1 press.
module key_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic key,
  output logic press
);

  logic key_q;
  logic key_qq;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      key_q  <= 1'b0;
      key_qq <= 1'b0;
    end else begin
      key_q  <= key;
      key_qq <= key_q;
    end
  end

  assign press = key_q & ~key_qq;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow sequencer: start, play, level-clear and end screens,
// with restart pulses for gameplay objects and the lose detector.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_LEVELS   = 3,
  parameter int unsigned CLEAR_FRAMES = CLEAR_FRAMES_DEF,
  parameter int unsigned END_FRAMES   = END_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startKey,
  input  logic        lost,
  input  logic        allAliensDead,
  output game_state_t gameState,
  output logic [3:0]  level,
  output logic        playEnable,
  output logic        levelResetN,
  output logic        gameResetN,
  output logic        showStart,
  output logic        showClear,
  output logic        showGameOver,
  output logic        showWin
);

  localparam int unsigned MAX_FRAMES =
    (CLEAR_FRAMES > END_FRAMES) ? CLEAR_FRAMES : END_FRAMES;
  localparam int unsigned CW = $clog2(MAX_FRAMES) + 1;

  logic          key_press;
  game_state_t   state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          first;
  logic          sof_cnt;
  logic          entering;
  logic          clear_done;

  key_edge_detect u_key (
    .clk    (clk),
    .resetN (resetN),
    .key    (startKey),
    .press  (key_press)
  );

  // Frames are ignored in the first cycle of a state.
  assign sof_cnt = startOfFrame && !first &&
                   (cnt != CW'(MAX_FRAMES));
  assign cnt_inc = cnt + {{(CW-1){1'b0}}, sof_cnt};

  always_comb begin
    state_n = gameState;
    case (gameState)
      IDLE:
        if (key_press) state_n = START_PULSE;
      START_PULSE:
        state_n = PLAYING;
      PLAYING:
        if (lost)
          state_n = GAME_OVER;
        else if (allAliensDead && level == 4'(NUM_LEVELS))
          state_n = WIN;
        else if (allAliensDead)
          state_n = LEVEL_CLEAR;
      LEVEL_CLEAR:
        if (cnt == CW'(CLEAR_FRAMES)) state_n = PLAYING;
      GAME_OVER, WIN:
        if (key_press && cnt >= CW'(END_FRAMES))
          state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
  end

  assign entering   = (state_n != gameState);
  // Level reset goes low in the last LEVEL_CLEAR cycle.
  assign clear_done = (gameState == LEVEL_CLEAR) && !entering &&
                      (cnt_inc == CW'(CLEAR_FRAMES));

  always_ff @(posedge clk) begin
    if (!resetN) begin
      gameState    <= IDLE;
      level        <= '0;
      cnt          <= '0;
      first        <= 1'b1;
      playEnable   <= 1'b0;
      levelResetN  <= 1'b1;
      gameResetN   <= 1'b1;
      showStart    <= 1'b1;
      showClear    <= 1'b0;
      showGameOver <= 1'b0;
      showWin      <= 1'b0;
    end else begin
      gameState <= state_n;
      {playEnable, showStart, showClear,
       showGameOver, showWin} <= screen_of(state_n);
      first       <= entering;
      cnt         <= entering ? '0 : cnt_inc;
      gameResetN  <= (state_n != START_PULSE);
      levelResetN <= !((state_n == START_PULSE) || clear_done);
      if (gameState == IDLE && entering)
        level <= 4'd1;
      else if (gameState == LEVEL_CLEAR && entering &&
               level < 4'(NUM_LEVELS))
        level <= level + 4'd1;
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl against a frame/level model.
module tb_game_state_ctrl;
  import game_pkg::*;

  localparam int NUM_LEVELS   = 3;
  localparam int CLEAR_FRAMES = 120;
  localparam int END_FRAMES   = 180;
  localparam int MAXF = (CLEAR_FRAMES > END_FRAMES) ? CLEAR_FRAMES : END_FRAMES;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic startOfFrame = 1'b0;
  logic startKey = 1'b0;
  logic lost = 1'b0;
  logic allAliensDead = 1'b0;
  game_state_t gameState;
  logic [3:0] level;
  logic playEnable, levelResetN, gameResetN;
  logic showStart, showClear, showGameOver, showWin;

  game_state_ctrl #(
    .NUM_LEVELS   (NUM_LEVELS),
    .CLEAR_FRAMES (CLEAR_FRAMES),
    .END_FRAMES   (END_FRAMES)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .startKey      (startKey),
    .lost          (lost),
    .allAliensDead (allAliensDead),
    .gameState     (gameState),
    .level         (level),
    .playEnable    (playEnable),
    .levelResetN   (levelResetN),
    .gameResetN    (gameResetN),
    .showStart     (showStart),
    .showClear     (showClear),
    .showGameOver  (showGameOver),
    .showWin       (showWin)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         e;
    logic [13:0] s;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  string phase = "reset";

  // Reference model: game mode, level and frames seen in the current mode
  typedef enum int {M_IDLE, M_SP, M_PLAY, M_LC, M_GO, M_WIN} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_lvl = 0;
  int    m_frames = 0;
  bit    m_fresh = 1'b1;
  logic  m_k1 = 1'b0;
  logic  m_k2 = 1'b0;
  logic [13:0] m_prev = 'x;

  function automatic logic [13:0] m_snap();
    logic [2:0] st;
    logic lrn;
    case (m_mode)
      M_IDLE:  st = IDLE;
      M_SP:    st = START_PULSE;
      M_PLAY:  st = PLAYING;
      M_LC:    st = LEVEL_CLEAR;
      M_GO:    st = GAME_OVER;
      default: st = WIN;
    endcase
    lrn = !(m_mode == M_SP || (m_mode == M_LC && m_frames == CLEAR_FRAMES));
    return {st, 4'(m_lvl), m_mode == M_PLAY, lrn, m_mode != M_SP,
            m_mode == M_IDLE, m_mode == M_LC, m_mode == M_GO,
            m_mode == M_WIN};
  endfunction

  task automatic model_step(input logic k, s, l, a, r);
    mode_t nx;
    bit press;
    logic [13:0] snap;
    exp_t ex;
    if (!r) begin
      m_mode = M_IDLE;
      m_lvl = 0;
      m_frames = 0;
      m_fresh = 1'b1;
      m_k1 = 1'b0;
      m_k2 = 1'b0;
    end else begin
      press = m_k1 && !m_k2;
      nx = m_mode;
      case (m_mode)
        M_IDLE: if (press) begin nx = M_SP; m_lvl = 1; end
        M_SP: nx = M_PLAY;
        M_PLAY:
          if (l) nx = M_GO;
          else if (a) nx = (m_lvl == NUM_LEVELS) ? M_WIN : M_LC;
        M_LC:
          if (m_frames == CLEAR_FRAMES) begin
            nx = M_PLAY;
            if (m_lvl < NUM_LEVELS) m_lvl = m_lvl + 1;
          end
        default: if (press && m_frames >= END_FRAMES) nx = M_IDLE;
      endcase
      if (nx != m_mode) begin
        m_frames = 0;
        m_fresh = 1'b1;
      end else begin
        if (s && !m_fresh && m_frames < MAXF) m_frames = m_frames + 1;
        m_fresh = 1'b0;
      end
      m_mode = nx;
      m_k2 = m_k1;
      m_k1 = k;
    end
    snap = m_snap();
    if (snap !== m_prev) begin
      ex.e = edge_n + 1;
      ex.s = snap;
      exp_q.push_back(ex);
      m_prev = snap;
    end
  endtask

  task automatic drive(input logic k, s, l, a, r);
    startKey = k;
    startOfFrame = s;
    lost = l;
    allAliensDead = a;
    resetN = r;
    model_step(k, s, l, a, r);
  endtask

  task automatic cyc(input logic k, s, l, a, r);
    @(negedge clk);
    drive(k, s, l, a, r);
  endtask

  function automatic logic rsof();
    return ($urandom_range(0, 2) == 0);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic press_key();
    repeat (3) cyc(1, rsof(), 0, 0, 1);
    repeat (2) cyc(0, rsof(), 0, 0, 1);
  endtask

  task automatic play(input int n);
    repeat (n) cyc(0, rsof(), 0, 0, 1);
  endtask

  task automatic run_clear();
    for (int i = 0; i < 5000 && m_mode == M_LC; i++)
      cyc(rbit(), rsof(), rbit(), rbit(), 1);
  endtask

  // Monitor: every change of the DUT's outputs consumes one expectation
  initial begin
    logic [13:0] prev;
    logic [13:0] cur;
    exp_t ex;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {gameState, level, playEnable, levelResetN, gameResetN,
             showStart, showClear, showGameOver, showWin};
      if (cur !== prev) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected change at edge %0d: got %b",
                   phase, edge_n, cur);
        end else begin
          ex = exp_q.pop_front();
          if (ex.e != edge_n || ex.s !== cur) begin
            n_fail++;
            $display("FAIL %s snapshot: got edge %0d %b, expected edge %0d %b",
                     phase, edge_n, cur, ex.e, ex.s);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    logic tk;
    drive(0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    repeat (4) cyc(0, rsof(), 0, 0, 1);

    phase = "start_a";
    press_key();
    play(10);
    phase = "clear_l1";
    cyc(0, rsof(), 0, 1, 1);
    run_clear();
    play(5);

    phase = "lost_and_clear";
    cyc(0, rsof(), 1, 1, 1);
    phase = "go_hold";
    for (int i = 0; i < 4000 && m_frames < END_FRAMES; i++)
      cyc(1, rsof(), 1, rbit(), 1);
    repeat (20) cyc(1, rsof(), 1, 0, 1);
    repeat (3) cyc(0, rsof(), 1, 0, 1);
    phase = "go_exit";
    press_key();

    phase = "start_b";
    press_key();
    play(6);
    for (int lv = 1; lv < NUM_LEVELS; lv++) begin
      phase = "clear_b";
      cyc(0, rsof(), 0, 1, 1);
      run_clear();
      play(4);
    end
    phase = "win";
    cyc(0, rsof(), 0, 1, 1);
    tk = 1'b0;
    for (int i = 0; i < 4000 && m_frames < END_FRAMES - 10; i++) begin
      if ($urandom_range(0, 5) == 0) tk = ~tk;
      cyc(tk, rsof(), rbit(), rbit(), 1);
    end
    for (int i = 0; i < 4000 && m_frames < END_FRAMES; i++)
      cyc(0, rsof(), 0, 0, 1);
    phase = "win_exit";
    press_key();

    phase = "rst_start_pulse";
    for (int i = 0; i < 10 && m_mode != M_SP; i++)
      cyc(1, rsof(), 0, 0, 1);
    cyc(1, rsof(), 0, 0, 0);
    play(5);

    phase = "rst_clear";
    press_key();
    play(5);
    cyc(0, rsof(), 0, 1, 1);
    for (int i = 0; i < 150 && m_mode == M_LC; i++)
      cyc(0, rsof(), 0, 0, 1);
    cyc(0, rsof(), 0, 0, 0);
    play(5);

    phase = "random";
    tk = 1'b0;
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) tk = ~tk;
      cyc(tk, rsof(), $urandom_range(0, 39) == 0,
          $urandom_range(0, 24) == 0, $urandom_range(0, 399) != 0);
    end

    phase = "drain";
    repeat (3) cyc(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected changes never seen, required 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
